hilo_muldiv_seq: RTL and testbench
==================================

# hilo_muldiv_seq

Multi-cycle multiply/divide sequencer that produces the 64-bit HI/LO result carried down the pipeline to the HI/LO write-back stage. It accepts MULT/MULTU/DIV/DIVU operations from EX and iterates a radix-2 shift-add or restoring-divide datapath over 32 cycles. It issues a one-cycle HI/LO write request with the packed result, and stalls the pipeline while a later instruction needs HI/LO or a new operation before the current one completes.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  EX issues a mul/div this cycle
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- flush  in  1  cancel any operation in flight
- mf_req  in  1  an MFHI/MFLO in EX needs HI/LO
- busy  out  1  operation in flight (MUL, DIV or DONE state)
- stall  out  1  freeze IF/ID/EX
- hilo_write  out  1  one-cycle HI/LO write strobe
- hilo_data  out  2*WIDTH  {HI, LO}

## Operation
- States: IDLE, MUL, DIV, DONE. Reset → IDLE.
- IDLE and start=1, flush=0: latch operands.
  - Signed ops latch magnitudes and record sign_q = a^b and sign_r = a.
  - Clear iteration counter. Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: each cycle, if multiplier LSB is set, add the multiplicand to the upper accumulator. Then shift the {acc, multiplier} register right by 1. After WIDTH iterations go to DONE.
- DIV: restoring step. Shift {rem, quot} left by 1. Trial-subtract the divisor from rem; if no borrow, keep the difference and set quot LSB. After WIDTH iterations go to DONE.
- DONE: apply sign fix-up, drive hilo_data and assert hilo_write for one cycle, then go to IDLE.
  - MULT: negate the 64-bit product if sign_q.
  - DIV: negate the quotient if sign_q; negate the remainder if sign_r.
  - Mul result is HI=upper, LO=lower. Div result is HI=remainder, LO=quotient.
- Divide by zero: HI=src_a (unmodified), LO=all ones, no sign fix-up. Normal latency.
- Signed overflow (-2^31 / -1): LO=0x80000000, HI=0.
- start while busy: ignored. stall already holds the issuing instruction in EX.
- flush in any state: go to IDLE next cycle, no hilo_write. flush wins over a simultaneous start and over DONE.
- stall = busy & (mf_req | start). It is deasserted in the cycle hilo_write is high, so MF reads the forwarded value next cycle.
- Arithmetic: the accumulator is WIDTH+1 bits to hold the carry. Negation is two's complement over the full field width.

## Timing
- Reset values: busy=0, stall=0, hilo_write=0, hilo_data=0, state IDLE, all internal registers 0.
- Start accepted on edge 0. Iterations complete on edges 1..WIDTH. DONE is the cycle after edge WIDTH. hilo_write is high during cycle WIDTH+1 after acceptance (33 cycles for WIDTH=32).
- hilo_data holds its last value until the next DONE.
- busy rises the cycle after acceptance and falls the cycle after DONE.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.
- rst asserted mid-operation: immediate return to IDLE with all outputs zero, no write.

## Configuration
- HILO_EARLY_TERM_EN defined:
  - Unsigned and signed multiply leave MUL once the remaining multiplier bits are all zero.
  - The accumulator is right-aligned by the remaining shift count in DONE.
  - Latency becomes 2 + (index of the highest set bit of |src_b|), with a minimum of 2.
  - Multiply by 0 finishes in 2 cycles. Divide is unaffected.
- Undefined: every operation takes exactly WIDTH iterations.

## Structure
- Shared package hilo_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state enum
  - default WIDTH constant
  - the divide-by-zero LO constant
- One sub-module, hilo_step: the combinational single-iteration add-shift / trial-subtract datapath, selected by a mode bit. The top holds the FSM, counter, sign bookkeeping and fix-up.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hilo_write 33 cycles after start, hilo_data=0xFFFFFFFE_00000001.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234 / 0 → HI=0x00001234, LO=0xFFFFFFFF, normal latency.
- Flush on iteration 10 with simultaneous start → no hilo_write, busy=0 next cycle, new start not taken.
- mf_req held during MUL → stall high every cycle through DONE-1, low in the hilo_write cycle. With HILO_EARLY_TERM_EN, MULTU x × 1 completes in 2 cycles.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    // LO value written for a divide by zero (sliced to the operand width)
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/hilo_step.sv
// One radix-2 iteration: shift-add multiply step (mode=0) or restoring divide step (mode=1).
module hilo_step
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             mode,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] rem_sh;

    always_comb begin
        sum    = lo[0] ? (acc + {1'b0, b}) : acc;
        rem_sh = {acc, lo[WIDTH-1]};
        if (mode) begin
            // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
            if (rem_sh >= {2'b00, b}) begin
                acc_next = (WIDTH+1)'(rem_sh - {2'b00, b});
                lo_next  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_sh[WIDTH:0];
                lo_next  = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {1'b0, sum[WIDTH:1]};
            lo_next  = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing the packed {HI, LO} write-back.
// Optional HILO_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module hilo_muldiv_seq
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    input  logic               mf_req,
    output logic               busy,
    output logic               stall,
    output logic               hilo_write,
    output logic [2*WIDTH-1:0] hilo_data
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   lo_next;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;
    logic [2*WIDTH-1:0] hilo_q;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               is_signed;
    logic               is_div;
    logic               last;
`ifdef HILO_EARLY_TERM_EN
    logic [WIDTH-1:0]   mpl_q;
`endif

    hilo_step #(.WIDTH(WIDTH)) u_step (
        .mode     (state_q == ST_DIV),
        .acc      (acc_q),
        .lo       (lo_q),
        .b        (b_q),
        .acc_next (acc_next),
        .lo_next  (lo_next)
    );

    always_comb begin
        is_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
        is_div    = (op_e'(op) == OP_DIVU) || (op_e'(op) == OP_DIV);
        a_mag     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

        last = (cnt_q == CW'(WIDTH - 1));
        prod = {acc_q[WIDTH-1:0], lo_q};
`ifdef HILO_EARLY_TERM_EN
        if ((state_q == ST_MUL) && ((mpl_q >> 1) == '0))
            last = 1'b1;
        // A short run leaves the product left-aligned by the skipped iterations
        prod = prod >> (CW'(WIDTH) - cnt_q);
`endif

        quot = neg_q ? -lo_q : lo_q;
        rem  = neg_r ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (!div_q)
            result = neg_q ? -prod : prod;
        else if (dz_q)
            result = {a_raw_q, DIV0_LO[WIDTH-1:0]};
        else
            result = {rem, quot};
    end

    assign busy       = (state_q != ST_IDLE);
    assign hilo_write = (state_q == ST_DONE) && !flush;
    assign hilo_data  = hilo_write ? result : hilo_q;
    assign stall      = busy && (mf_req || start) && !hilo_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            a_raw_q <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            hilo_q  <= '0;
`ifdef HILO_EARLY_TERM_EN
            mpl_q   <= '0;
`endif
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        lo_q    <= is_div ? a_mag : b_mag;
                        b_q     <= is_div ? b_mag : a_mag;
                        a_raw_q <= src_a;
                        div_q   <= is_div;
                        neg_q   <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r   <= is_signed && src_a[WIDTH-1];
                        dz_q    <= is_div && (src_b == '0);
`ifdef HILO_EARLY_TERM_EN
                        mpl_q   <= b_mag;
`endif
                        state_q <= is_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= acc_next;
                    lo_q  <= lo_next;
                    cnt_q <= cnt_q + 1'b1;
`ifdef HILO_EARLY_TERM_EN
                    mpl_q <= mpl_q >> 1;
`endif
                    if (last)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    hilo_q  <= result;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq: results, latency, stall, flush and reset behaviour.
module tb_hilo_muldiv_seq;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        mf_req = 1'b0;
    logic        busy;
    logic        stall;
    logic        hilo_write;
    logic [63:0] hilo_data;

    typedef struct {
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_data = '0;

    hilo_muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .mf_req     (mf_req),
        .busy       (busy),
        .stall      (stall),
        .hilo_write (hilo_write),
        .hilo_data  (hilo_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sbv, q, r;
        logic [63:0] p;
        sa  = a;
        sbv = b;
        case (o)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int early;
        m = (o[0] && b[31]) ? -b : b;
        early = 2;
        for (int i = 0; i < 32; i++)
            if (m[i]) early = 2 + i;
`ifdef HILO_EARLY_TERM_EN
        return o[1] ? 33 : early;
`else
        return (early > 0) ? 33 : 0;
`endif
    endfunction

    // Issue one op, follow it to its write strobe, then score latency and data.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit mf, input int poke);
        exp_t e;
        int   lat;
        bit   seen;
        bit   poked;
        e.data = model(o, a, b);
        e.lat  = exp_lat(o, b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; mf_req = mf;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1; seen = 1'b0; poked = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (poked) begin start = 1'b0; poked = 1'b0; end
            if (hilo_write) seen = 1'b1;
            if (mf) begin
                checks++;
                if (stall !== (lat < e.lat)) begin
                    failures++;
                    $display("FAIL %s_stall cycle %0d: got %b want %b", nm, lat, stall, (lat < e.lat));
                end
            end
            if (!seen && lat == poke) begin
                start = 1'b1; op = ~o; src_a = ~a; src_b = b + 32'd1;
                #1;
                checks++;
                if (stall !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy_start_stall: got %b want 1", nm, stall);
                end
                poked = 1'b1;
            end
            if (!seen) lat++;
        end
        start = 1'b0;
        mf_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || lat != e.lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d (write seen=%0d) want %0d", nm, lat, seen, e.lat);
        end
        checks++;
        if (!seen || hilo_data !== e.data) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", nm, hilo_data, e.data);
        end
        last_data = e.data;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, stall, hilo_write} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000", {busy, stall, hilo_write});
        end
        checks++;
        if (hilo_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", hilo_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_multu();
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("multu_x1", OP_MULTU, 32'hDEAD_BEEF, 32'h1, 1'b0, -1);
        run_op("multu_x0", OP_MULTU, 32'h1234_5678, 32'h0, 1'b0, -1);
    endtask

    task automatic test_mult();
        run_op("mult_m3x5", OP_MULT, -32'sd3, 32'd5, 1'b0, -1);
        run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("mult_7xm1", OP_MULT, 32'd7, 32'hFFFF_FFFF, 1'b0, -1);
    endtask

    task automatic test_div();
        run_op("div_m7d2", OP_DIV, -32'sd7, 32'd2, 1'b0, -1);
        run_op("div_7dm2", OP_DIV, 32'd7, -32'sd2, 1'b0, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 1'b0, -1);
    endtask

    task automatic test_div_zero();
        run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 1'b0, -1);
        run_op("div_zero_neg", OP_DIV, -32'sd5, 32'h0, 1'b0, -1);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (hilo_data !== last_data || busy !== 1'b0 || hilo_write !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got data=%h busy=%b wr=%b want %h 0 0", i, hilo_data, busy, hilo_write, last_data);
            end
        end
    endtask

    task automatic test_flush_iter10();
        int writes;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd5;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: got %b want 0", busy);
        end
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hilo_write) writes++;
        end
        checks++;
        if (writes != 0 || busy !== 1'b0 || hilo_data !== last_data) begin
            failures++;
            $display("FAIL flush_nowrite: got writes=%0d busy=%b data=%h want 0 0 %h", writes, busy, hilo_data, last_data);
        end
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (33) @(negedge clk);
        checks++;
        if (hilo_write !== 1'b1) begin
            failures++;
            $display("FAIL flush_done_reach: got %b want 1", hilo_write);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (hilo_write !== 1'b0 || hilo_data !== last_data) begin
            failures++;
            $display("FAIL flush_done_gate: got wr=%b data=%h want 0 %h", hilo_write, hilo_data, last_data);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hilo_data !== last_data) begin
            failures++;
            $display("FAIL flush_done_after: got busy=%b data=%h want 0 %h", busy, hilo_data, last_data);
        end
    endtask

    task automatic test_stall();
        run_op("stall_mf", OP_MULTU, 32'hCAFE_0001, 32'h8765_4321, 1'b1, -1);
    endtask

    task automatic test_start_busy();
        run_op("start_busy", OP_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0, -1);
        run_op("b2b_second", OP_MULT, -32'sd100, -32'sd200, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        int writes;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'd77; src_b = 32'd99;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        mf_req = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, stall, hilo_write} !== 3'b000 || hilo_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid: got ctrl=%b data=%h want 000 0", {busy, stall, hilo_write}, hilo_data);
        end
        @(negedge clk);
        rst = 1'b1; mf_req = 1'b0;
        last_data = '0;
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hilo_write) writes++;
        end
        checks++;
        if (writes != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: got writes=%0d busy=%b want 0 0", writes, busy);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 300));
                default: b = -32'($urandom_range(1, 300));
            endcase
            run_op($sformatf("rand%0d", i), o, a, b, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_hold();
        test_flush_iter10();
        test_flush_done();
        test_stall();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
